// File: rtl/link_pulse_gen.sv
// 10BASE-T link integrity pulse generator: NLP single pulses or FLP 33-slot
// autonegotiation bursts, suppressed while the data transmitter is busy.
module link_pulse_gen #(
    parameter int PULSE_CYCLES    = 4,
    parameter int SLOT_CYCLES     = 2500,
    parameter int INTERVAL_CYCLES = 640000,
    parameter int CNT_W           = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mode,
    input  logic [15:0] code_word,
    input  logic        tx_busy,
    output logic        link,
    output logic        busy,
    output logic        burst_start,
    output logic        burst_done
);

    localparam int SCNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0]  IC_LAST    = CNT_W'(INTERVAL_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'(SLOT_CYCLES - 1);
    localparam logic [SCNT_W-1:0] PULSE_LIM  = SCNT_W'(PULSE_CYCLES);

    if (PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("link_pulse_gen: PULSE_CYCLES must be >= 1");
    end
    if (SLOT_CYCLES <= PULSE_CYCLES) begin : g_bad_slot
        $error("link_pulse_gen: SLOT_CYCLES must exceed PULSE_CYCLES");
    end
    if (INTERVAL_CYCLES <= 33 * SLOT_CYCLES) begin : g_bad_interval
        $error("link_pulse_gen: INTERVAL_CYCLES must exceed 33*SLOT_CYCLES");
    end
    if (64'(INTERVAL_CYCLES - 1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("link_pulse_gen: CNT_W too narrow for INTERVAL_CYCLES-1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    ic_r, ic_s;
    logic [SCNT_W-1:0]   scnt_r, scnt_s;
    logic [5:0]          slot_r, slot_s;
    logic                mode_r, mode_s;
    logic [15:0]         cw_r, cw_s;
    logic                link_r, link_s;
    logic                busy_r, busy_s;
    logic                start_r, start_s;
    logic                done_r, done_s;
    logic [5:0]          last_slot_s;

    // Even slots are clock pulses; odd slot 2k+1 carries code word bit k.
    function automatic logic pulse_present(input logic [5:0] slot, input logic [15:0] cw);
        return !slot[0] || cw[slot[4:1]];
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, interval counter and slot sequencing
    always_comb begin
        state_s     = state_r;
        scnt_s      = scnt_r;
        slot_s      = slot_r;
        mode_s      = mode_r;
        cw_s        = cw_r;
        start_s     = 1'b0;
        done_s      = 1'b0;
        last_slot_s = mode_r ? 6'd32 : 6'd0;
        if (tx_busy) begin
            ic_s = CNT_W'(1);
        end else if (ic_r == IC_LAST) begin
            ic_s = '0;
        end else begin
            ic_s = ic_r + CNT_W'(1);
        end
        case (state_r)
            IDLE: begin
                if ((ic_r == '0) && en && !tx_busy) begin
                    state_s = BURST;
                    mode_s  = mode;
                    cw_s    = code_word;
                    slot_s  = 6'd0;
                    scnt_s  = '0;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (tx_busy) begin
                    state_s = IDLE;
                    slot_s  = 6'd0;
                    scnt_s  = '0;
                end else if (scnt_r == SCNT_LAST) begin
                    scnt_s = '0;
                    if (slot_r == last_slot_s) begin
                        state_s = IDLE;
                        slot_s  = 6'd0;
                        done_s  = 1'b1;
                    end else begin
                        slot_s = slot_r + 6'd1;
                    end
                end else begin
                    scnt_s = scnt_r + SCNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                slot_s  = 6'd0;
                scnt_s  = '0;
            end
        endcase
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        busy_s = (state_s == BURST);
        if (state_s == BURST) begin
            link_s = (scnt_s < PULSE_LIM) && pulse_present(slot_s, cw_s);
        end else begin
            link_s = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_r    <= '0;
            scnt_r  <= '0;
            slot_r  <= 6'd0;
            mode_r  <= 1'b0;
            cw_r    <= 16'h0000;
            link_r  <= 1'b0;
            busy_r  <= 1'b0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ic_r    <= ic_s;
            scnt_r  <= scnt_s;
            slot_r  <= slot_s;
            mode_r  <= mode_s;
            cw_r    <= cw_s;
            link_r  <= link_s;
            busy_r  <= busy_s;
            start_r <= start_s;
            done_r  <= done_s;
        end
    end

    // tx_busy must kill the pulse within the same cycle, not a cycle later.
    assign link        = link_r & ~tx_busy;
    assign busy        = busy_r;
    assign burst_start = start_r;
    assign burst_done  = done_r;

endmodule

// File: tb/tb_link_pulse_gen.sv
// Bench for link_pulse_gen: per-cycle reference model, burst table and corner sequences.
module tb_link_pulse_gen;
    localparam int PULSE = 4;
    localparam int SLOT  = 20;
    localparam int INTV  = 1000;

    logic        clk = 1'b0;
    logic        rst, en, mode, tx_busy;
    logic [15:0] code_word;
    logic        link, busy, burst_start, burst_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    bit          m_active = 1'b0;
    int          m_off    = 0;
    bit          m_mode   = 1'b0;
    logic [15:0] m_cw     = 16'h0000;
    int          m_ic     = 0;
    bit          m_link = 1'b0, m_start = 1'b0, m_done = 1'b0;

    link_pulse_gen #(
        .PULSE_CYCLES(PULSE), .SLOT_CYCLES(SLOT), .INTERVAL_CYCLES(INTV), .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .code_word(code_word),
        .tx_busy(tx_busy), .link(link), .busy(busy),
        .burst_start(burst_start), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          md;
        logic [15:0] cw;
        int          exp_rises;
        int          exp_done;
    } vec_t;
    vec_t tbl[5];

    function automatic bit pulse_at(int off, logic [15:0] cw);
        int s = off / SLOT;
        int p = off % SLOT;
        if (p >= PULSE) return 1'b0;
        if (s % 2 == 0) return 1'b1;
        return cw[s / 2];
    endfunction

    task automatic chk(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 30) $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Model one clock edge from the rules: offset within burst, interval phase.
    task automatic model_edge();
        int len;
        m_start = 1'b0;
        m_done  = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_off = 0; m_ic = 0;
        end else begin
            len = m_mode ? 33 * SLOT : SLOT;
            if (m_active) begin
                if (tx_busy) m_active = 1'b0;
                else if (m_off + 1 == len) begin m_active = 1'b0; m_done = 1'b1; end
                else m_off++;
            end else if (m_ic == 0 && en && !tx_busy) begin
                m_active = 1'b1; m_off = 0; m_mode = mode; m_cw = code_word; m_start = 1'b1;
            end
            m_ic = tx_busy ? 1 : (m_ic + 1) % INTV;
        end
        m_link = m_active && pulse_at(m_off, m_cw);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("m_link", link, m_link & ~tx_busy);
        chk("m_busy", busy, m_active);
        chk("m_start", burst_start, m_start);
        chk("m_done", burst_done, m_done);
    endtask

    task automatic wait_start(output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!burst_start && waited < 2100);
        if (!burst_start) chk("start_timeout", 1'b0, 1'b1);
    endtask

    // kind: 0 none, 1 switch to NLP/FFFF, 2 drop en -- applied at offset chg_off
    task automatic measure(input int kind, input int chg_off, output int rises, output int done_off);
        int  w;
        bit  prev;
        wait_start(w);
        rises    = link ? 1 : 0;
        prev     = link;
        done_off = -1;
        for (int off = 1; off <= 700; off++) begin
            if (off == chg_off && kind == 1) begin code_word = 16'hFFFF; mode = 1'b0; end
            if (off == chg_off && kind == 2) en = 1'b0;
            step();
            if (link && !prev) rises++;
            prev = link;
            if (burst_done && done_off < 0) done_off = off;
        end
    endtask

    initial begin
        int w, r, d, n_start, n_high, n_done, first_done;
        tbl[0] = '{1'b0, 16'h0000,  1,  20};
        tbl[1] = '{1'b1, 16'hA5A5, 25, 660};
        tbl[2] = '{1'b1, 16'h0000, 17, 660};
        tbl[3] = '{1'b1, 16'hFFFF, 33, 660};
        tbl[4] = '{1'b1, 16'h0001, 18, 660};

        rst = 1'b1; en = 1'b0; mode = 1'b0; code_word = 16'h0000; tx_busy = 1'b0;
        repeat (3) step();
        chk("rst_link", link, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // NLP over five intervals
        rst = 1'b0; en = 1'b1;
        step();
        chk("nlp_first_start", burst_start, 1'b1);
        chk("nlp_first_link", link, 1'b1);
        n_start = 1; n_high = 1; n_done = 0; first_done = -1;
        for (int i = 2; i <= 5000; i++) begin
            step();
            if (burst_start) n_start++;
            if (link) n_high++;
            if (burst_done) begin n_done++; if (first_done < 0) first_done = i; end
        end
        chk_int("nlp_starts", n_start, 5);
        chk_int("nlp_high_cycles", n_high, 20);
        chk_int("nlp_dones", n_done, 5);
        chk_int("nlp_done_step", first_done, 21);

        // burst table
        for (int t = 0; t < 5; t++) begin
            mode = tbl[t].md; code_word = tbl[t].cw;
            measure(0, -1, r, d);
            chk_int("tbl_rises", r, tbl[t].exp_rises);
            chk_int("tbl_done_off", d, tbl[t].exp_done);
        end

        // mid-burst mode/code_word change is ignored
        mode = 1'b1; code_word = 16'hA5A5;
        measure(1, 100, r, d);
        chk_int("mid_rises", r, 25);
        chk_int("mid_done_off", d, 660);
        measure(0, -1, r, d);
        chk_int("next_nlp_rises", r, 1);
        chk_int("next_nlp_done", d, 20);

        // tx_busy abort at offset 300 (odd slot 15, bit 7 set)
        mode = 1'b1; code_word = 16'hA5A5;
        wait_start(w);
        for (int i = 1; i <= 300; i++) step();
        chk("pre_abort_link", link, 1'b1);
        tx_busy = 1'b1;
        #1;
        chk("abort_link_now", link, 1'b0);
        step();
        chk("abort_busy", busy, 1'b0);
        n_done = burst_done ? 1 : 0;
        for (int i = 1; i < 50; i++) begin step(); if (burst_done) n_done++; end
        chk_int("abort_no_done", n_done, 0);
        tx_busy = 1'b0;
        wait_start(w);
        chk_int("restart_edges", w, 1000);

        // en dropped mid-burst
        measure(2, 50, r, d);
        chk_int("en_rises", r, 25);
        chk_int("en_done_off", d, 660);
        n_start = 0;
        for (int i = 0; i < 1500; i++) begin step(); if (burst_start) n_start++; end
        chk_int("en_blocked", n_start, 0);
        en = 1'b1;
        wait_start(w);
        chk_int("en_resume_edges", w, 800);

        // reset mid-burst
        for (int i = 1; i <= 199; i++) step();
        rst = 1'b1;
        step();
        chk("rst_mid_link", link, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_start", burst_start, 1'b0);
        chk("rst_mid_done", burst_done, 1'b0);
        rst = 1'b0;
        step();
        chk("rst_fresh_start", burst_start, 1'b1);

        // randomized traffic against the model
        begin
            int bl = 0;
            for (int i = 0; i < 20000; i++) begin
                if (bl > 0) begin tx_busy = 1'b1; bl--; end
                else begin
                    tx_busy = 1'b0;
                    if ($urandom_range(0, 299) == 0) bl = $urandom_range(1, 60);
                end
                rst       = ($urandom_range(0, 4999) == 0);
                en        = ($urandom_range(0, 9) != 0);
                mode      = 1'($urandom_range(0, 1));
                code_word = 16'($urandom);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
